gpio_apb_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and APB master sequencer in front of the GPIO APB slave.

---
 rtl/gpio_apb_arbiter.sv | 158 +++++++++++++++
 tb/tb_gpio_apb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_apb_arbiter.sv
// gpio_apb_arbiter: two-requester round-robin arbiter and APB master sequencer for the GPIO slave
//
// Ports:
//   PCLK, PRESET        clock (rising edge) and asynchronous active-high reset
//   reqN_valid/write    requester N transfer request and direction (1=write)
//   reqN_addr/wdata     register address (0=data, 1=direction) and write data
//   reqN_ready          combinational grant, high only for the arbitration winner in IDLE
//   rspN_valid/rdata/err one-cycle completion pulse with read data and error flag
//   PSEL..PWDATA        registered APB master outputs
//   PRDATA, PREADY      APB slave read data and ready
//
// Optional build: define GPIO_ARB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT
// consecutive cycles with PREADY=0 and report it as an error.
module gpio_apb_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_nx;
    logic last_grant, last_grant_nx, owner, owner_nx;
    logic psel_nx, penable_nx, pwrite_nx;
    logic [ADDR_W-1:0] paddr_nx, sel_addr;
    logic [DATA_W-1:0] pwdata_nx, sel_wdata, rsp_d;
    logic gnt, accept, sel_write, rsp_v, rsp_e, expired;

    // Both valid: the one not granted last time wins; otherwise the only valid one.
    assign gnt = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign accept = (state == IDLE) & ~PRESET & (req0_valid | req1_valid);
    assign req0_ready = accept & ~gnt;
    assign req1_ready = accept & gnt;
    assign sel_write = gnt ? req1_write : req0_write;
    assign sel_addr = gnt ? req1_addr : req0_addr;
    assign sel_wdata = gnt ? req1_wdata : req0_wdata;

`ifdef GPIO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt, cnt_nx;
    // Counts completed ACCESS cycles; zero on entry to ACCESS, so it fires on cycle TIMEOUT.
    assign expired = cnt == CW'(TIMEOUT - 1);
    assign cnt_nx = (state == ACCESS) ? cnt + 1'b1 : '0;
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            cnt <= '0;
        else
            cnt <= cnt_nx;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign expired = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        last_grant_nx = last_grant;
        owner_nx = owner;
        psel_nx = PSEL;
        penable_nx = PENABLE;
        pwrite_nx = PWRITE;
        paddr_nx = PADDR;
        pwdata_nx = PWDATA;
        rsp_v = 1'b0;
        rsp_e = 1'b0;
        rsp_d = '0;
        case (state)
            IDLE: if (accept) begin
                last_grant_nx = gnt;
                owner_nx = gnt;
                // Only registers 0 and 1 exist; anything else fails without touching the bus.
                if (|sel_addr[ADDR_W-1:1]) begin
                    rsp_v = 1'b1;
                    rsp_e = 1'b1;
                end else begin
                    state_nx = SETUP;
                    psel_nx = 1'b1;
                    penable_nx = 1'b0;
                    pwrite_nx = sel_write;
                    paddr_nx = sel_addr;
                    pwdata_nx = sel_write ? sel_wdata : '0;
                end
            end
            SETUP: begin
                state_nx = ACCESS;
                penable_nx = 1'b1;
            end
            ACCESS: if (PREADY | expired) begin
                state_nx = IDLE;
                psel_nx = 1'b0;
                penable_nx = 1'b0;
                rsp_v = 1'b1;
                rsp_e = ~PREADY;
                rsp_d = (PREADY & ~PWRITE) ? PRDATA : '0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
            last_grant <= 1'b1;
            owner <= 1'b0;
            PSEL <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE <= 1'b0;
            PADDR <= '0;
            PWDATA <= '0;
            rsp0_valid <= 1'b0;
            rsp0_err <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_err <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            state <= state_nx;
            last_grant <= last_grant_nx;
            owner <= owner_nx;
            PSEL <= psel_nx;
            PENABLE <= penable_nx;
            PWRITE <= pwrite_nx;
            PADDR <= paddr_nx;
            PWDATA <= pwdata_nx;
            rsp0_valid <= rsp_v & ~owner_nx;
            rsp0_err <= rsp_v & rsp_e & ~owner_nx;
            rsp0_rdata <= (rsp_v & ~owner_nx) ? rsp_d : '0;
            rsp1_valid <= rsp_v & owner_nx;
            rsp1_err <= rsp_v & rsp_e & owner_nx;
            rsp1_rdata <= (rsp_v & owner_nx) ? rsp_d : '0;
        end
    end
endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// tb_gpio_apb_arbiter: directed and randomized self-checking bench for gpio_apb_arbiter
`timescale 1ns/1ps
module tb_gpio_apb_arbiter;
    localparam int TO = 4;
    logic PCLK = 1'b0;
    logic PRESET;
    logic req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
    logic req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
    logic [7:0] req0_addr, req0_wdata, rsp0_rdata, req1_addr, req1_wdata, rsp1_rdata;
    logic PSEL, PENABLE, PWRITE, PREADY;
    logic [7:0] PADDR, PWDATA, PRDATA;

    always #5 PCLK = ~PCLK;

    gpio_apb_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    // Pending request per requester, held until the model says it was accepted.
    logic rq_v[2], rq_w[2];
    logic [7:0] rq_a[2], rq_d[2];
    assign req0_valid = rq_v[0];
    assign req0_write = rq_w[0];
    assign req0_addr = rq_a[0];
    assign req0_wdata = rq_d[0];
    assign req1_valid = rq_v[1];
    assign req1_write = rq_w[1];
    assign req1_addr = rq_a[1];
    assign req1_wdata = rq_d[1];

    int vectors = 0, miscompares = 0;
    // Transaction-level reference: one APB window [ap_s, ap_e] and one expected response.
    int cyc, free_at, ap_s, ap_e, rs_cyc, force_w, p_valid, p_ill;
    bit ap_on, rs_on, m_last, rs_own, rs_err, ap_w, autogen, stuck;
    logic [7:0] ap_a, ap_d, rs_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic win, acc, e_sel, e_en, e_rv;
        int wt;
        if (autogen)
            for (int i = 0; i < 2; i++)
                if (!rq_v[i] && $urandom_range(0, 99) < p_valid) begin
                    rq_v[i] = 1'b1;
                    rq_w[i] = 1'($urandom);
                    rq_a[i] = ($urandom_range(0, 99) < p_ill) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
                    rq_d[i] = 8'($urandom);
                end
        PREADY = ap_on && !stuck && cyc == ap_e;
        PRDATA = autogen ? 8'($urandom) : 8'hA5;
        #1;
        win = (rq_v[0] && rq_v[1]) ? ~m_last : rq_v[1];
        acc = cyc >= free_at && (rq_v[0] || rq_v[1]);
        chk("req0_ready", req0_ready, acc && !win);
        chk("req1_ready", req1_ready, acc && win);
        e_sel = ap_on && cyc >= ap_s && cyc <= ap_e;
        e_en = e_sel && cyc > ap_s;
        chk("PSEL", PSEL, e_sel);
        chk("PENABLE", PENABLE, e_en);
        if (e_sel) begin
            chk("PADDR", PADDR, ap_a);
            chk("PWRITE", PWRITE, ap_w);
            chk("PWDATA", PWDATA, ap_w ? ap_d : 8'h00);
        end
        if (ap_on && !stuck && cyc == ap_e)
            rs_rdata = ap_w ? 8'h00 : PRDATA;
        e_rv = rs_on && cyc == rs_cyc;
        chk("rsp0_valid", rsp0_valid, e_rv && !rs_own);
        chk("rsp0_err", rsp0_err, e_rv && !rs_own && rs_err);
        chk("rsp0_rdata", rsp0_rdata, (e_rv && !rs_own) ? rs_rdata : 8'h00);
        chk("rsp1_valid", rsp1_valid, e_rv && rs_own);
        chk("rsp1_err", rsp1_err, e_rv && rs_own && rs_err);
        chk("rsp1_rdata", rsp1_rdata, (e_rv && rs_own) ? rs_rdata : 8'h00);
        if (acc) begin
            m_last = win;
            wt = force_w >= 0 ? force_w : $urandom_range(0, TO - 1);
            rs_on = 1'b1;
            rs_own = win;
            rs_err = 1'b0;
            rs_rdata = 8'h00;
            if (rq_a[win] > 8'd1) begin
                ap_on = 1'b0;
                rs_err = 1'b1;
                rs_cyc = cyc + 1;
            end else begin
                ap_on = 1'b1;
                ap_s = cyc + 1;
                ap_w = rq_w[win];
                ap_a = rq_a[win];
                ap_d = rq_d[win];
                if (stuck) begin
`ifdef GPIO_ARB_TIMEOUT_EN
                    ap_e = cyc + 1 + TO;
                    rs_err = 1'b1;
`else
                    ap_e = cyc + 1000;
`endif
                end else
                    ap_e = cyc + 2 + wt;
                rs_cyc = ap_e + 1;
            end
            free_at = rs_cyc;
        end
        @(posedge PCLK);
        #1;
        cyc++;
        if (acc)
            rq_v[win] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (rq_v[0] || rq_v[1] || (rs_on && cyc <= rs_cyc)); i++)
            step();
    endtask

    task automatic set_req(input int n, input logic w, input logic [7:0] a, input logic [7:0] d);
        rq_v[n] = 1'b1;
        rq_w[n] = w;
        rq_a[n] = a;
        rq_d[n] = d;
    endtask

    initial begin
        PRESET = 1'b1;
        PREADY = 1'b0;
        PRDATA = 8'h00;
        for (int i = 0; i < 2; i++) begin
            rq_v[i] = 1'b0;
            rq_w[i] = 1'b0;
            rq_a[i] = 8'h00;
            rq_d[i] = 8'h00;
        end
        cyc = 0; free_at = 0; ap_on = 0; rs_on = 0; m_last = 1;
        force_w = -1; autogen = 0; stuck = 0; p_valid = 0; p_ill = 0;
        repeat (2) @(posedge PCLK);
        #1;
        set_req(0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_PSEL", PSEL, 1'b0);
        chk("rst_PENABLE", PENABLE, 1'b0);
        chk("rst_PWRITE", PWRITE, 1'b0);
        chk("rst_PADDR", PADDR, 8'h00);
        chk("rst_PWDATA", PWDATA, 8'h00);
        chk("rst_rsp0", {rsp0_valid, rsp0_err, rsp0_rdata}, 10'h0);
        chk("rst_rsp1", {rsp1_valid, rsp1_err, rsp1_rdata}, 10'h0);
        PRESET = 1'b0;

        // Both requesters valid continuously from reset: grants alternate starting with req0.
        autogen = 1; p_valid = 100; p_ill = 0; force_w = 0;
        repeat (12) step();
        autogen = 0;
        drain();

        // req0 write to direction register, zero wait states.
        set_req(0, 1'b1, 8'h01, 8'hFF);
        drain();

        // req1 read of data register with two wait states.
        force_w = 2;
        set_req(1, 1'b0, 8'h00, 8'h00);
        drain();

        // Illegal address from req0 alongside a legal req1 read.
        force_w = 1;
        set_req(0, 1'b1, 8'h05, 8'h3C);
        set_req(1, 1'b0, 8'h01, 8'h00);
        drain();

        // Randomized traffic.
        autogen = 1; p_valid = 60; p_ill = 15; force_w = -1;
        repeat (400) step();
        autogen = 0;
        drain();

        // Reset during ACCESS drops the transfer; req0 wins first afterwards.
        force_w = 5;
        set_req(0, 1'b0, 8'h00, 8'h00);
        repeat (3) step();
        PRESET = 1'b1;
        #1;
        chk("arst_PSEL", PSEL, 1'b0);
        chk("arst_PENABLE", PENABLE, 1'b0);
        chk("arst_rsp0_valid", rsp0_valid, 1'b0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        cyc++;
        ap_on = 0; rs_on = 0; m_last = 1; free_at = 0;
        force_w = 0;
        set_req(0, 1'b1, 8'h00, 8'h5A);
        set_req(1, 1'b0, 8'h01, 8'h00);
        drain();

        // Slave never ready.
        stuck = 1;
        set_req(1, 1'b0, 8'h01, 8'h00);
`ifdef GPIO_ARB_TIMEOUT_EN
        repeat (TO + 3) step();
`else
        repeat (102) step();
`endif
        stuck = 0;
        PRESET = 1'b1;
        #1;
        chk("end_PSEL", PSEL, 1'b0);
        chk("end_PENABLE", PENABLE, 1'b0);
        PRESET = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
